mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the instruction-fetch requester (I) and the memory-stage data requester (D).
- Sits between the core and the memory/cache interface. Serialises transactions and routes each response back to the requester that issued it.
- Fixed priority favours D, so a memory-stage stall resolves first. A starvation limiter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I is pending before I is forced through; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  fetch request; held high until i_data_ok.
- i_addr  in  64  fetch address, 4-byte aligned.
- i_addr_ok  out  1  fetch address accepted.
- i_data_ok  out  1  fetch data valid; transaction complete.
- i_data  out  32  instruction word.
- d_valid  in  1  data request; held high until d_data_ok.
- d_addr  in  64  data address.
- d_size  in  3  access size code (0=1B, 1=2B, 2=4B, 3=8B).
- d_strobe  in  8  byte write enables; 0 means read.
- d_wdata  in  64  write data.
- d_addr_ok  out  1  data address accepted.
- d_data_ok  out  1  data response valid.
- d_rdata  out  64  read data.
- m_valid  out  1  downstream request.
- m_addr  out  64  downstream address.
- m_size  out  3  downstream size.
- m_strobe  out  8  downstream byte enables.
- m_wdata  out  64  downstream write data.
- m_addr_ok  in  1  downstream address accepted.
- m_data_ok  in  1  downstream response valid.
- m_rdata  in  64  downstream read data.
- busy_d  out  1  current owner is D (debug/perf).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- State machine: IDLE, BUSY_I, BUSY_D. Reset sets state IDLE, starvation counter 0, and the round-robin pointer (optional feature) to I. All outputs are 0 while reset is asserted.
- IDLE, arbitration registered at the clock edge:
  - D wins if d_valid and NOT (i_valid and counter >= STARVE_LIMIT).
  - Otherwise I wins if i_valid.
  - Otherwise stay in IDLE.
  - Outputs in IDLE: m_valid=0 and all requester *_ok=0.
- BUSY_I:
  - m_valid=i_valid, m_addr=i_addr, m_size=3'd2, m_strobe=0, m_wdata=0.
  - i_addr_ok=m_addr_ok.
  - i_data_ok=m_data_ok.
  - i_data = i_addr[2] ? m_rdata[63:32] : m_rdata[31:0].
- BUSY_D:
  - m_* fields are passed through from d_*.
  - d_addr_ok=m_addr_ok, d_data_ok=m_data_ok, d_rdata=m_rdata.
- Isolation: the non-owner always sees *_ok=0. Its data output is 0.
- Completion: when m_data_ok is high in BUSY_x, the next state is IDLE. Exactly one bubble cycle follows, so the completed requester's still-high valid is never double-granted.
- Latency: a request raised at cycle N in IDLE produces m_valid at N+1. The minimum round trip is N+1 when memory answers combinationally; the port is idle again at N+2.
- Starvation counter:
  - Increments (saturating at 2^CNT_W-1) on each D grant made while i_valid=1.
  - Clears on any I grant.
  - Clears on a D grant made while i_valid=0.
- Simultaneous events: m_addr_ok and m_data_ok in the same cycle are both forwarded, and the transaction completes. A requester raising valid in the completion cycle waits for the next IDLE arbitration.
- Reset mid-transaction:
  - The state is forced to IDLE immediately and m_valid drops asynchronously.
  - Any response arriving after reset release while IDLE is ignored and not forwarded.
- Protocol violation (owner drops valid before data_ok): m_valid follows the owner's valid, and the state is held until m_data_ok. No recovery is attempted.
- busy_d = (state==BUSY_D).

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- When defined:
  - Fixed priority and the starvation counter are replaced by a 1-bit last-grant pointer.
  - On a tie, the requester not granted last wins.
  - A lone requester always wins.
  - The pointer updates on every grant and resets to I, so the first tie after reset goes to D.
  - STARVE_LIMIT and CNT_W are ignored.
- When undefined: the fixed-priority and starvation behaviour above applies.

Test Plan:
- I-only read: i_valid=1, i_addr=0x8000_0004; memory returns m_rdata=0x1111_2222_3333_4444 at cycle 2 → m_valid at cycle 1 with m_size=2 and m_strobe=0; i_data=0x1111_2222 and i_data_ok=1 at cycle 2; d_data_ok stays 0.
- Tie: i_valid and d_valid rise together, d_addr=0x100, d_strobe=0xFF, d_wdata=0xDEAD → D granted first (busy_d=1, m_wdata=0xDEAD); I is granted after the bubble cycle.
- Starvation, STARVE_LIMIT=4: i_valid held high, d_valid re-raised after each completion → D receives 4 grants, the 5th grant goes to I, then D resumes.
- Isolation: during BUSY_D with m_data_ok=1 and m_rdata=0xABCD → d_rdata=0xABCD, d_data_ok=1; i_data_ok=0 and i_data=0.
- Async reset mid-BUSY_D: assert reset between clock edges → m_valid=0 and busy_d=0 immediately. A subsequent m_data_ok after release is not forwarded to either requester.
- With MEM_ARB_ROUND_ROBIN_EN: both requesters held continuously valid → grant order D, I, D, I over four transactions.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch (I) and data (D) requesters;
//            D has fixed priority, with a starvation limiter so fetch still
//            makes progress. Define MEM_ARB_ROUND_ROBIN_EN for round-robin.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  // fetch requester
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  // data requester
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  // downstream memory port
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [63:0] m_rdata,
  // debug
  output logic        busy_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_d, grant_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;  // 1 when the most recent grant went to D

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_valid && i_valid) begin
      grant_d = ~last_d_q;
      grant_i = last_d_q;
    end else begin
      grant_d = d_valid;
      grant_i = i_valid;
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (grant_d || grant_i)) last_d_d = grant_d;
  end
`else
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_valid && !(i_valid && (cnt_q >= CNT_W'(STARVE_LIMIT)))) grant_d = 1'b1;
    else grant_i = i_valid;
  end

  // Counts consecutive D grants that overtook a waiting fetch.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (grant_d) begin
        if (!i_valid) cnt_d = '0;
        else if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else if (grant_i) begin
        cnt_d = '0;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)      state_d = BUSY_D;
        else if (grant_i) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (m_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the owner is routed; everything else, including IDLE, reads as 0.
  always_comb begin
    m_valid   = 1'b0;
    m_addr    = '0;
    m_size    = '0;
    m_strobe  = '0;
    m_wdata   = '0;
    i_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    i_data    = '0;
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    d_rdata   = '0;
    unique case (state_q)
      BUSY_I: begin
        m_valid   = i_valid;
        m_addr    = i_addr;
        m_size    = 3'd2;
        i_addr_ok = m_addr_ok;
        i_data_ok = m_data_ok;
        i_data    = i_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
      end
      BUSY_D: begin
        m_valid   = d_valid;
        m_addr    = d_addr;
        m_size    = d_size;
        m_strobe  = d_strobe;
        m_wdata   = d_wdata;
        d_addr_ok = m_addr_ok;
        d_data_ok = m_data_ok;
        d_rdata   = m_rdata;
      end
      default: ;
    endcase
  end

  assign busy_d = (state_q == BUSY_D);

endmodule
`default_nettype wire
